// File: rtl/lab_exam.sv
// Go-timed step counter: counts synchronized rising edges of Clk while go is high,
// saturating at COUNT_MAX, and drives an 8-digit multiplexed seven-segment display.
module lab_exam #(
    parameter int SCAN_DIV  = 4,
    parameter int COUNT_MAX = 99
) (
    input  logic       Clk_unscaled,
    input  logic       Rst,
    input  logic       Clk,
    input  logic       go,
    output logic [6:0] count,
    output logic       done,
    output logic [6:0] out7,
    output logic [7:0] scr_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COUNT,
        S_DONE
    } state_e;

    localparam int             PW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0]  PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [6:0]     CNT_MAX  = 7'(COUNT_MAX);
    localparam logic [6:0]     SEG_BLANK = 7'b1111111;

    // Synchronizers and step edge detector
    logic clk_s1_q, clk_s2_q, clk_s3_q;
    logic go_s1_q, go_s2_q;
    logic step;

    // Counter FSM
    state_e     state_q, state_d;
    logic [6:0] count_q, count_d;
    logic       done_q, done_d;

    // Display scan
    logic [PW-1:0] pre_q, pre_d;
    logic [2:0]    idx_q, idx_d;
    logic [6:0]    out7_q, out7_d;
    logic [7:0]    scr_q, scr_d;
    logic [3:0]    ones, tens;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would collapse the synchronizer chain.
    always_ff @(posedge Clk_unscaled or posedge Rst) begin
        if (Rst) begin
            clk_s1_q <= 1'b0;
            clk_s2_q <= 1'b0;
            clk_s3_q <= 1'b0;
            go_s1_q  <= 1'b0;
            go_s2_q  <= 1'b0;
        end else begin
            clk_s1_q <= Clk;
            clk_s2_q <= clk_s1_q;
            clk_s3_q <= clk_s2_q;
            go_s1_q  <= go;
            go_s2_q  <= go_s1_q;
        end
    end

    assign step = clk_s2_q & ~clk_s3_q;

    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = done_q;
        if (step) begin
            case (state_q)
                S_IDLE: begin
                    if (go_s2_q) begin
                        count_d = 7'd1;
                        state_d = S_COUNT;
                    end
                end
                S_COUNT: begin
                    if (go_s2_q) begin
                        count_d = (count_q >= CNT_MAX) ? CNT_MAX : count_q + 7'd1;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    if (go_s2_q) begin
                        count_d = 7'd1;
                        done_d  = 1'b0;
                        state_d = S_COUNT;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk_unscaled or posedge Rst) begin
        if (Rst) begin
            state_q <= S_IDLE;
            count_q <= 7'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    assign ones = 4'(count_q % 7'd10);
    assign tens = 4'(count_q / 7'd10);

    // Segments and enables are computed from the next digit index so both
    // registers always describe the same slot.
    always_comb begin
        if (pre_q == PRE_LAST) begin
            pre_d = '0;
            idx_d = idx_q + 3'd1;
        end else begin
            pre_d = pre_q + PW'(1);
            idx_d = idx_q;
        end
        scr_d = ~(8'd1 << idx_d);
        case (idx_d)
            3'd0:    out7_d = seg_of(ones);
            3'd1:    out7_d = seg_of(tens);
            default: out7_d = SEG_BLANK;
        endcase
    end

    always_ff @(posedge Clk_unscaled or posedge Rst) begin
        if (Rst) begin
            pre_q  <= '0;
            idx_q  <= 3'd0;
            out7_q <= 7'b1000000;
            scr_q  <= 8'b11111110;
        end else begin
            pre_q  <= pre_d;
            idx_q  <= idx_d;
            out7_q <= out7_d;
            scr_q  <= scr_d;
        end
    end

    assign count   = count_q;
    assign done    = done_q;
    assign out7    = out7_q;
    assign scr_out = scr_q;

endmodule

// File: tb/tb_lab_exam.sv
// Directed bench for lab_exam: table-driven step vectors plus hand-written
// sequences for step latency, saturation, display scan and asynchronous reset.
module tb_lab_exam;

    logic       Clk_unscaled;
    logic       Rst;
    logic       Clk;
    logic       go;
    logic [6:0] count;
    logic       done;
    logic [6:0] out7;
    logic [7:0] scr_out;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic       go;
        logic [6:0] cnt;
        logic       done;
    } vec_t;

    vec_t vecs[$];

    lab_exam #(
        .SCAN_DIV (4),
        .COUNT_MAX(99)
    ) dut (
        .Clk_unscaled(Clk_unscaled),
        .Rst         (Rst),
        .Clk         (Clk),
        .go          (go),
        .count       (count),
        .done        (done),
        .out7        (out7),
        .scr_out     (scr_out)
    );

    initial Clk_unscaled = 1'b0;
    always #5 Clk_unscaled = ~Clk_unscaled;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge Clk_unscaled);
    endtask

    // One step: go set up 2 cycles early, Clk high 4 cycles and low 4 cycles.
    task automatic do_step(input logic g);
        go = g;
        tick(2);
        Clk = 1'b1;
        tick(4);
        Clk = 1'b0;
        tick(4);
    endtask

    task automatic wait_scr(input logic [7:0] val, input string name);
        int n = 0;
        while (scr_out !== val && n < 100) begin
            @(negedge Clk_unscaled);
            n++;
        end
        check(name, scr_out, val);
    endtask

    task automatic reset_pulse();
        Rst = 1'b1;
        tick(2);
        Rst = 1'b0;
        tick(1);
    endtask

    function automatic logic [6:0] scan8_seg(input int digit);
        if (digit == 0) return 7'b0000000;
        if (digit == 1) return 7'b1000000;
        return 7'b1111111;
    endfunction

    initial begin
        vec_t v;
        logic [7:0] exp_scr;

        for (int i = 0; i < 3; i++) vecs.push_back('{go: 1'b0, cnt: 7'd0, done: 1'b0});
        for (int i = 1; i <= 8; i++) vecs.push_back('{go: 1'b1, cnt: 7'(i), done: 1'b0});
        vecs.push_back('{go: 1'b0, cnt: 7'd8, done: 1'b1});
        vecs.push_back('{go: 1'b0, cnt: 7'd8, done: 1'b1});
        vecs.push_back('{go: 1'b1, cnt: 7'd1, done: 1'b0});
        vecs.push_back('{go: 1'b1, cnt: 7'd2, done: 1'b0});

        Rst = 1'b1;
        Clk = 1'b0;
        go  = 1'b1;
        #1;
        check("rst_count", count, 7'd0);
        check("rst_done", done, 1'b0);
        check("rst_scr", scr_out, 8'b11111110);
        check("rst_out7", out7, 7'b1000000);

        repeat (3) do_step(1'b1);
        check("rst_held_count", count, 7'd0);
        check("rst_held_done", done, 1'b0);
        Rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            do_step(v.go);
            check($sformatf("vec%0d_count", i), count, v.cnt);
            check($sformatf("vec%0d_done", i), done, v.done);
        end

        // Step latency: update lands on the 3rd rising edge after Clk rises.
        go = 1'b1;
        tick(2);
        Clk = 1'b1;
        tick(2);
        check("lat_before", count, 7'd2);
        tick(1);
        check("lat_after", count, 7'd3);
        tick(1);
        Clk = 1'b0;
        tick(4);

        do_step(1'b0);
        check("sat_pre_done", done, 1'b1);
        check("sat_pre_count", count, 7'd3);
        for (int i = 1; i <= 120; i++) begin
            do_step(1'b1);
            if (i == 1 || i == 99 || i == 100 || i == 120)
                check($sformatf("sat_step%0d", i), count, (i > 99) ? 7'd99 : 7'(i));
        end
        check("sat_done", done, 1'b0);
        wait_scr(8'b11111110, "sat_scr_d0");
        check("sat_out7_d0", out7, 7'b0010000);
        wait_scr(8'b11111101, "sat_scr_d1");
        check("sat_out7_d1", out7, 7'b0010000);

        // Scan walk with count = 8, two full scans, every cycle of every slot.
        reset_pulse();
        repeat (8) do_step(1'b1);
        check("scan_count", count, 7'd8);
        wait_scr(8'b01111111, "scan_align7");
        wait_scr(8'b11111110, "scan_align0");
        for (int k = 0; k < 16; k++) begin
            exp_scr = ~(8'd1 << (k % 8));
            for (int c = 0; c < 4; c++) begin
                check($sformatf("scan_scr_s%0d_c%0d", k, c), scr_out, exp_scr);
                check($sformatf("scan_out7_s%0d_c%0d", k, c), out7, scan8_seg(k % 8));
                @(negedge Clk_unscaled);
            end
        end

        // Asynchronous reset in the middle of a run.
        reset_pulse();
        repeat (5) do_step(1'b1);
        check("mid_count5", count, 7'd5);
        #2 Rst = 1'b1;
        #1;
        check("mid_rst_count", count, 7'd0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_scr", scr_out, 8'b11111110);
        check("mid_rst_out7", out7, 7'b1000000);
        @(negedge Clk_unscaled);
        Rst = 1'b0;
        do_step(1'b1);
        check("mid_after1", count, 7'd1);
        do_step(1'b1);
        check("mid_after2", count, 7'd2);
        check("mid_after_done", done, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/lab_exam.md
# lab_exam

Go-timed event counter with an 8-digit multiplexed seven-segment display driver. While `go` is held high, `lab_exam` counts rising edges of a slow step strobe `Clk`. When `go` falls it freezes the count and raises `done`. It sits between a board-level clock divider, which supplies `Clk`, and the display pins. The count is shown as two decimal digits.

## Interface
Parameters:
- `SCAN_DIV`, default 4: number of `Clk_unscaled` cycles each display digit is held active (≥1).
- `COUNT_MAX`, default 99: saturation value of `count`.

Ports:
- `Clk_unscaled`  in  1  the single clock of the block; all flops are on its rising edge.
- `Rst`  in  1  asynchronous, active-high reset.
- `Clk`  in  1  slow step strobe, treated as data (not a clock); each rising edge is one step.
- `go`  in  1  run request, sampled at each step.
- `count`  out  7  steps counted in the current run, unsigned, saturating at `COUNT_MAX`.
- `done`  out  1  high after a run has ended, until the next run starts.
- `out7`  out  7  segments {g,f,e,d,c,b,a}, active-low.
- `scr_out`  out  8  digit enables, active-low one-hot; bit 0 is the rightmost digit.

## Operation
- **Step detection**
  - `Clk` and `go` each pass through a 2-flop synchronizer; a third flop on `Clk` feeds edge detection.
  - `step` is a one-cycle pulse when the synchronized `Clk` goes 0→1.
  - `go` is evaluated only when `step` is high, using its synchronized value from the same cycle.
- **FSM states:** IDLE, COUNT, DONE.
  - IDLE, step with go=1: `count`←1, go to COUNT.
  - IDLE, step with go=0: stay in IDLE.
  - COUNT, step with go=1: `count`←min(`count`+1, `COUNT_MAX`).
  - COUNT, step with go=0: `done`←1, go to DONE, hold `count`.
  - DONE, step with go=1: `count`←1, `done`←0, go to COUNT.
  - DONE, step with go=0: stay in DONE and hold.
  - Without a step, nothing changes.
- **Display**
  - A 3-bit digit index advances every `SCAN_DIV` cycles and wraps 7→0.
  - `scr_out` = ~(1<<index).
  - Digit 0 shows `count`%10 and digit 1 shows `count`/10; digit 1 also shows 0 when `count`<10. Digits 2–7 are blank (7'b1111111).
  - Segment codes, active-low:
    - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
    - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - `out7` and `scr_out` are registered together, so the segment pattern always matches the enabled digit.
- **Arithmetic:** `count` is 7-bit unsigned and never wraps; the BCD split is pure combinational divide/modulo by 10 on 0..99.

## Timing
- **Reset values** (immediate on `Rst`, independent of the clock): state IDLE, `count`=0, `done`=0, digit index 0, scan prescaler 0, `scr_out`=8'b11111110, `out7`=7'b1000000, all synchronizer flops 0.
- **Reset mid-run:** aborts the run to the reset values above; the first step after release follows the IDLE rules.
- **Step latency:** `count`/`done` update on the 3rd `Clk_unscaled` rising edge after `Clk` rises (2 sync + 1 register).
- **`Clk` width:** high and low phases must each be ≥3 `Clk_unscaled` cycles; narrower pulses may be missed.
- **`go` setup:** changes to `go` must precede the `Clk` rising edge by ≥1 `Clk_unscaled` cycle to be seen on that step.
- **Display:** a change of `count` appears on `out7` no later than the next digit-0 or digit-1 slot. One full scan takes 8×`SCAN_DIV` cycles.

## Test plan
- Reset held across several steps, then released with go=0 and 3 steps: `count`=0, `done`=0, `scr_out`=11111110 immediately after reset, `out7`=1000000.
- go high for 8 steps, then low at the 9th step: `count` is 1..8 on successive steps; at the 9th step `done`=1 and `count` holds 8.
- From DONE, go high for 2 steps: `count` restarts at 1 then 2, and `done` falls on the first step.
- go high for 120 steps: `count` saturates at 99 with no wrap; digit 0 and digit 1 each show pattern 0010000.
- Scan check with `count`=8: `scr_out` walks 11111110→11111101→…→01111111 and wraps, each slot lasting 4 cycles. Digit 0 shows 0000000, digit 1 shows 1000000, all other digits show 1111111.
- `Rst` asserted while `count`=5 in COUNT: asynchronous return to reset values, then normal counting from 1 after release.
